// File: rtl/alu_driver.sv
// alu_driver
//   Front end for simple_alu. Takes a whole operation (opcode, A, B) on a
//   valid/ready command port and plays it onto the ALU's two-cycle
//   opcode_valid/data protocol: A in the first cycle, B in the second. It then
//   waits for done, captures result/overflow, and offers them on a valid/ready
//   response port. A done-timeout ends the wait if the ALU never answers, and
//   op_count counts accepted responses.
//
// Ports
//   clk           in   rising-edge clock
//   reset_n       in   asynchronous active-low reset
//   cmd_valid     in   command present
//   cmd_ready     out  command can be accepted (IDLE only)
//   cmd_opcode    in   ALU opcode
//   cmd_a, cmd_b  in   operands
//   opcode_valid  out  to ALU: operand phase active
//   opcode        out  to ALU: opcode
//   data          out  to ALU: operand bus
//   done          in   from ALU: result valid this cycle
//   result        in   from ALU: result
//   overflow      in   from ALU: overflow flag
//   rsp_valid     out  response present
//   rsp_ready     in   consumer accepts response
//   rsp_result    out  captured result (0 on timeout)
//   rsp_overflow  out  captured overflow (0 on timeout)
//   rsp_timeout   out  operation ended by timeout
//   op_count      out  completed responses, wraps at 2^16
//
// State table
//   state     | meaning
//   IDLE      | cmd_ready high, waiting for a command
//   SEND_A    | opcode_valid high, operand A on data
//   SEND_B    | opcode_valid high, operand B on data
//   WAIT_DONE | ALU bus idle, waiting for done or timeout
//   RESP      | rsp_valid high, fields held until rsp_ready

module alu_driver #(
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_opcode,
  input  logic [DATA_WIDTH-1:0] cmd_a,
  input  logic [DATA_WIDTH-1:0] cmd_b,
  output logic                  opcode_valid,
  output logic                  opcode,
  output logic [DATA_WIDTH-1:0] data,
  input  logic                  done,
  input  logic [DATA_WIDTH-1:0] result,
  input  logic                  overflow,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_overflow,
  output logic                  rsp_timeout,
  output logic [15:0]           op_count
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND_A    = 3'd1,
    SEND_B    = 3'd2,
    WAIT_DONE = 3'd3,
    RESP      = 3'd4
  } state_t;

  // Counter value on the last WAIT_DONE cycle: it is cleared on entry, so
  // this places rsp_valid exactly TIMEOUT cycles after WAIT_DONE begins.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t                state, state_nxt;
  logic [7:0]            tmo_cnt, tmo_cnt_nxt;
  logic [DATA_WIDTH-1:0] b_q, b_nxt;

  logic                  cmd_ready_nxt;
  logic                  opcode_valid_nxt;
  logic                  opcode_nxt;
  logic [DATA_WIDTH-1:0] data_nxt;
  logic                  rsp_valid_nxt;
  logic [DATA_WIDTH-1:0] rsp_result_nxt;
  logic                  rsp_overflow_nxt;
  logic                  rsp_timeout_nxt;
  logic [15:0]           op_count_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      tmo_cnt      <= '0;
      b_q          <= '0;
      cmd_ready    <= 1'b1;
      opcode_valid <= 1'b0;
      opcode       <= 1'b0;
      data         <= '0;
      rsp_valid    <= 1'b0;
      rsp_result   <= '0;
      rsp_overflow <= 1'b0;
      rsp_timeout  <= 1'b0;
      op_count     <= '0;
    end else begin
      state        <= state_nxt;
      tmo_cnt      <= tmo_cnt_nxt;
      b_q          <= b_nxt;
      cmd_ready    <= cmd_ready_nxt;
      opcode_valid <= opcode_valid_nxt;
      opcode       <= opcode_nxt;
      data         <= data_nxt;
      rsp_valid    <= rsp_valid_nxt;
      rsp_result   <= rsp_result_nxt;
      rsp_overflow <= rsp_overflow_nxt;
      rsp_timeout  <= rsp_timeout_nxt;
      op_count     <= op_count_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    tmo_cnt_nxt      = tmo_cnt;
    b_nxt            = b_q;
    cmd_ready_nxt    = cmd_ready;
    opcode_valid_nxt = opcode_valid;
    opcode_nxt       = opcode;
    data_nxt         = data;
    rsp_valid_nxt    = rsp_valid;
    rsp_result_nxt   = rsp_result;
    rsp_overflow_nxt = rsp_overflow;
    rsp_timeout_nxt  = rsp_timeout;
    op_count_nxt     = op_count;

    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          // A goes straight onto the bus; only B needs holding for a cycle.
          b_nxt            = cmd_b;
          opcode_nxt       = cmd_opcode;
          opcode_valid_nxt = 1'b1;
          data_nxt         = cmd_a;
          cmd_ready_nxt    = 1'b0;
          state_nxt        = SEND_A;
        end
      end

      SEND_A: begin
        data_nxt  = b_q;
        state_nxt = SEND_B;
      end

      SEND_B: begin
        opcode_valid_nxt = 1'b0;
        opcode_nxt       = 1'b0;
        data_nxt         = '0;
        tmo_cnt_nxt      = '0;
        state_nxt        = WAIT_DONE;
      end

      WAIT_DONE: begin
        tmo_cnt_nxt = tmo_cnt + 8'd1;
        if (done) begin
          rsp_valid_nxt    = 1'b1;
          rsp_result_nxt   = result;
          rsp_overflow_nxt = overflow;
          rsp_timeout_nxt  = 1'b0;
          state_nxt        = RESP;
        end else if (tmo_cnt == TMO_LAST) begin
          rsp_valid_nxt    = 1'b1;
          rsp_result_nxt   = '0;
          rsp_overflow_nxt = 1'b0;
          rsp_timeout_nxt  = 1'b1;
          state_nxt        = RESP;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          cmd_ready_nxt = 1'b1;
          op_count_nxt  = op_count + 16'd1;
          state_nxt     = IDLE;
        end
      end

      default: begin
        state_nxt        = IDLE;
        cmd_ready_nxt    = 1'b1;
        opcode_valid_nxt = 1'b0;
        opcode_nxt       = 1'b0;
        data_nxt         = '0;
        rsp_valid_nxt    = 1'b0;
      end
    endcase
  end

endmodule
